// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared types and constants for the multi-port register file.
//   - state_t    : clear-engine state (ST_IDLE, ST_CLEAR)
//   - ZERO_ADDR  : address of the hardwired-zero entry
//   - DATA_W_DEF : default data width
//   - ADDR_W_DEF : default address width
package regfile_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam int ZERO_ADDR  = 0;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

endpackage

// File: rtl/regfile_clear_fsm.sv
// regfile_clear_fsm
//   Sequential clear engine. It walks clr_idx from 0 to DEPTH-1, one entry
//   per cycle, asserting clr_we so the parent writes zero to that entry.
//   Ports:
//     clock     in   system clock, rising edge
//     reset     in   synchronous active-low reset (forces a fresh clear)
//     clear_req in   request a full clear; sampled only in ST_IDLE
//     busy      out  1 while in ST_CLEAR
//     clr_we    out  write-zero strobe for entry clr_idx
//     clr_idx   out  entry being cleared this cycle
//     state_dbg out  current state, exposed for checkers
//   Handshake: clear_req is a level request with no acknowledge; it is
//   consumed on the rising edge where the engine is in ST_IDLE, and is
//   ignored (not queued) while busy=1.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_idx,
    output state_t            state_dbg
);

    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_nxt;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ST_CLEAR;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            ST_IDLE: begin
                if (clear_req) begin
                    state_nxt = ST_CLEAR;
                    idx_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                // Index wraps back to 0 naturally after the last entry.
                idx_nxt = idx + 1'b1;
                if (idx == LAST_IDX) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_CLEAR;
                idx_nxt   = '0;
            end
        endcase
    end

    assign busy      = (state == ST_CLEAR);
    assign clr_we    = (state == ST_CLEAR);
    assign clr_idx   = idx;
    assign state_dbg = state;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp
//   Parametrised multi-port register file for the pipelined MIPS datapath.
//   Rising-edge writes, combinational reads, and a clear engine that zeroes
//   the array one entry per cycle after reset or on clear_req.
//   Optional feature macro: REGFILE_BYPASS_EN
//     defined   : same-cycle write-to-read bypass (write-first view)
//     undefined : reads return stored contents only
//   Ports:
//     clock     in   system clock, rising edge
//     reset     in   synchronous active-low reset
//     clear_req in   request a full-array clear
//     busy      out  clear engine running; array not usable
//     rd_addr   in   NUM_RD*ADDR_W read addresses, port i at [i*ADDR_W +: ADDR_W]
//     rd_data   out  NUM_RD*DATA_W read data, port i at [i*DATA_W +: DATA_W]
//     wr_en     in   NUM_WR per-port write enables
//     wr_addr   in   NUM_WR*ADDR_W write addresses
//     wr_data   in   NUM_WR*DATA_W write data
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear_req,
    output logic                     busy,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_idx;
    state_t            clr_state;
    logic              wr_ok;

    regfile_clear_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clear (
        .clock     (clock),
        .reset     (reset),
        .clear_req (clear_req),
        .busy      (busy),
        .clr_we    (clr_we),
        .clr_idx   (clr_idx),
        .state_dbg (clr_state)
    );

    function automatic logic is_zero_addr(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == ADDR_W'(ZERO_ADDR));
    endfunction

    // Normal writes only land in IDLE and outside reset.
    assign wr_ok = reset && (clr_state == ST_IDLE);

    // Ports are visited in ascending order, so the highest-index port
    // writing a given address wins.
    always_ff @(posedge clock) begin
        if (clr_we) begin
            mem[clr_idx] <= '0;
        end else if (wr_ok) begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && !is_zero_addr(wr_addr[j*ADDR_W +: ADDR_W])) begin
                    mem[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rv;

        assign ra = rd_addr[i*ADDR_W +: ADDR_W];

        always_comb begin
            rv = mem[ra];
`ifdef REGFILE_BYPASS_EN
            // Ascending scan: the last match is the highest-index writer.
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == ra)) begin
                    rv = wr_data[j*DATA_W +: DATA_W];
                end
            end
`endif
            // Busy masking also hides the unknown contents before the
            // first clear completes.
            if (busy || is_zero_addr(ra)) begin
                rv = '0;
            end
        end

        assign rd_data[i*DATA_W +: DATA_W] = rv;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp
//   Directed bench for regfile_mp with default parameters
//   (DATA_W=32, ADDR_W=5, NUM_RD=2, NUM_WR=2, ZERO_REG=1).
//   Expectations for same-cycle reads follow REGFILE_BYPASS_EN.
module tb_regfile_mp;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;
    localparam int NUM_WR = 2;
    localparam int DEPTH  = 32;

    logic                     clock = 1'b0;
    logic                     reset = 1'b0;
    logic                     clear_req = 1'b0;
    logic                     busy;
    logic [NUM_RD*ADDR_W-1:0] rd_addr = '0;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_WR-1:0]        wr_en = '0;
    logic [NUM_WR*ADDR_W-1:0] wr_addr = '0;
    logic [NUM_WR*DATA_W-1:0] wr_data = '0;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] exp_q[$];

    regfile_mp #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (1)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .clear_req (clear_req),
        .busy      (busy),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_check(input string tag, input logic [DATA_W-1:0] obs);
        logic [DATA_W-1:0] exp;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            exp = exp_q.pop_front();
            check(tag, {32'd0, obs}, {32'd0, exp});
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_wr(input int port, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_en[port]                   = 1'b1;
        wr_addr[port*ADDR_W +: ADDR_W] = a;
        wr_data[port*DATA_W +: DATA_W] = d;
    endtask

    task automatic idle_wr();
        wr_en = '0;
    endtask

    task automatic set_rd(input int port, input logic [ADDR_W-1:0] a);
        rd_addr[port*ADDR_W +: ADDR_W] = a;
    endtask

    function automatic logic [DATA_W-1:0] rd(input int port);
        return rd_data[port*DATA_W +: DATA_W];
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int rd_bad;
        logic [DATA_W-1:0] same_cycle;

        // Test 1: reset held for 2 edges, then a 32-edge clear.
        reset = 1'b0;
        @(posedge clock); #1;
        check("rst_busy", {63'd0, busy}, 64'd1);
        check("rst_rd0", {32'd0, rd(0)}, 64'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        n = 0;
        rd_bad = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clock); #1;
            n++;
            if (!busy) break;
            if (rd_data !== '0) rd_bad++;
            set_rd(0, ADDR_W'($urandom_range(0, DEPTH-1)));
            set_rd(1, ADDR_W'($urandom_range(0, DEPTH-1)));
        end
        // Edge 32 after release writes entry 31 and returns to IDLE.
        check("t1_busy_len", 64'(n), 64'd32);
        check("t1_rd_zero_busy", 64'(rd_bad), 64'd0);
        for (int a = 0; a < DEPTH; a++) begin
            set_rd(0, ADDR_W'(a));
            set_rd(1, ADDR_W'(DEPTH-1-a));
            #1;
            check($sformatf("t1_entry_p0_%0d", a), {32'd0, rd(0)}, 64'd0);
            check($sformatf("t1_entry_p1_%0d", DEPTH-1-a), {32'd0, rd(1)}, 64'd0);
        end

        // Test 2: both ports write address 5; port 1 wins.
        @(negedge clock);
        drive_wr(0, 5'd5, 32'h11);
        drive_wr(1, 5'd5, 32'h22);
        @(negedge clock);
        idle_wr();
        set_rd(0, 5'd5);
        exp_q.push_back(32'h22);
        #1;
        sb_check("t2_same_addr", rd(0));

        // Test 3: write-then-read of address 8 in the same cycle.
`ifdef REGFILE_BYPASS_EN
        same_cycle = 32'hDEADBEEF;
`else
        same_cycle = 32'h0;
`endif
        @(negedge clock);
        drive_wr(0, 5'd8, 32'hDEADBEEF);
        set_rd(0, 5'd8);
        exp_q.push_back(same_cycle);
        #1;
        sb_check("t3_same_cycle", rd(0));
        @(negedge clock);
        idle_wr();
        exp_q.push_back(32'hDEADBEEF);
        #1;
        sb_check("t3_next_cycle", rd(0));

        // Test 3b: bypass priority with both ports hitting address 12.
`ifdef REGFILE_BYPASS_EN
        same_cycle = 32'hBB;
`else
        same_cycle = 32'h0;
`endif
        @(negedge clock);
        drive_wr(0, 5'd12, 32'hAA);
        drive_wr(1, 5'd12, 32'hBB);
        set_rd(1, 5'd12);
        exp_q.push_back(same_cycle);
        #1;
        sb_check("t3b_bypass_prio", rd(1));
        @(negedge clock);
        idle_wr();
        exp_q.push_back(32'hBB);
        #1;
        sb_check("t3b_stored_prio", rd(1));

        // Independent writes on both ports, crossed reads.
        @(negedge clock);
        drive_wr(0, 5'd10, 32'hA5A5_0010);
        drive_wr(1, 5'd20, 32'h5A5A_0020);
        @(negedge clock);
        idle_wr();
        set_rd(0, 5'd20);
        set_rd(1, 5'd10);
        #1;
        check("two_port_rd0", {32'd0, rd(0)}, 64'h5A5A_0020);
        check("two_port_rd1", {32'd0, rd(1)}, 64'hA5A5_0010);

        // Test 4: address 0 is hardwired to zero, even under bypass.
        @(negedge clock);
        drive_wr(1, 5'd0, 32'hFFFF_FFFF);
        set_rd(0, 5'd0);
        set_rd(1, 5'd0);
        #1;
        check("t4_zero_same_p0", {32'd0, rd(0)}, 64'd0);
        check("t4_zero_same_p1", {32'd0, rd(1)}, 64'd0);
        @(negedge clock);
        idle_wr();
        #1;
        check("t4_zero_next", {32'd0, rd(0)}, 64'd0);
        @(negedge clock);
        #1;
        check("t4_zero_later", {32'd0, rd(1)}, 64'd0);

        // Test 5: clear_req wipes the array; writes during clear dropped.
        @(negedge clock);
        drive_wr(0, 5'd3, 32'h1234);
        @(negedge clock);
        idle_wr();
        set_rd(0, 5'd3);
        #1;
        check("t5_pre_clear", {32'd0, rd(0)}, 64'h1234);
        @(negedge clock);
        clear_req = 1'b1;
        n = 0;
        rd_bad = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clock); #1;
            n++;
            if (!busy) break;
            if (rd(0) !== '0) rd_bad++;
            if (n == 1) clear_req = 1'b0;
            if (n == 5) clear_req = 1'b1;   // ignored: no restart
            if (n == 6) clear_req = 1'b0;
            if (n == 20) drive_wr(0, 5'd3, 32'h55);  // after entry 3 cleared
            if (n == 21) idle_wr();
        end
        // One accepting edge plus 32 clear edges.
        check("t5_busy_len", 64'(n), 64'd33);
        check("t5_rd_zero_busy", 64'(rd_bad), 64'd0);
        check("t5_addr3_after", {32'd0, rd(0)}, 64'd0);

        // Test 6: reset at cycle 10 of a clear restarts the full sweep.
        @(negedge clock);
        clear_req = 1'b1;
        @(posedge clock); #1;
        clear_req = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock); #1;
        check("t6_busy_in_reset", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clock); #1;
            n++;
            if (!busy) break;
        end
        check("t6_busy_len", 64'(n), 64'd32);

        // Array usable again after the restarted clear.
        @(negedge clock);
        drive_wr(1, 5'd31, 32'hCAFE_F00D);
        @(negedge clock);
        idle_wr();
        set_rd(1, 5'd31);
        #1;
        check("t6_post_write", {32'd0, rd(1)}, 64'hCAFE_F00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
